// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Captures the decoded control bundle and operands, detects load-use hazards
// against the instruction currently in EX, and inserts bubbles on a load-use
// hazard or a taken-branch flush. Also keeps a saturating count of inserted bubbles.
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ValidD,
    input  logic             RegWriteD,
    input  logic             ALUSrcD,
    input  logic             MemWriteD,
    input  logic             ResultSrcD,
    input  logic             BranchD,
    input  logic [2:0]       ALUControlD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [4:0]       RS1D,
    input  logic [4:0]       RS2D,
    input  logic [4:0]       RdD,
    input  logic             PCSrcE,
    output logic             ValidE,
    output logic             RegWriteE,
    output logic             ALUSrcE,
    output logic             MemWriteE,
    output logic             ResultSrcE,
    output logic             BranchE,
    output logic [2:0]       ALUControlE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [4:0]       RS1E,
    output logic [4:0]       RS2E,
    output logic [4:0]       RdE,
    output logic             StallF,
    output logic             StallD,
    output logic [CNT_W-1:0] BubbleCnt
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            alu_src;
        logic            mem_write;
        logic            result_src;
        logic            branch;
        logic [2:0]      alu_control;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } ex_bundle_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ex_bundle_t       ex_d;
    ex_bundle_t       ex_q;
    logic [CNT_W-1:0] bubble_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic             load_use_s;
    logic             insert_bubble_s;

    // Hazard: a valid load in EX whose non-x0 destination feeds either source of the D instruction.
    // RS2 is compared for every format; I-type false positives only cost a bubble.
    always_comb begin
        load_use_s = ex_q.valid & ex_q.reg_write & ex_q.result_src & (ex_q.rd != 5'd0) & ValidD
                     & ((ex_q.rd == RS1D) | (ex_q.rd == RS2D));
        insert_bubble_s = PCSrcE | load_use_s;
    end

    // A taken branch squashes the D instruction, so it overrides the stall; no stall during reset.
    assign StallF = load_use_s & ~PCSrcE & ~rst;
    assign StallD = load_use_s & ~PCSrcE & ~rst;

    // Next EX contents: an all-zero NOP on flush or bubble, otherwise the decoded instruction.
    always_comb begin
        ex_d = '0;
        if (insert_bubble_s) begin
            ex_d = '0;
        end else begin
            ex_d.valid       = ValidD;
            ex_d.reg_write   = RegWriteD;
            ex_d.alu_src     = ALUSrcD;
            ex_d.mem_write   = MemWriteD;
            ex_d.result_src  = ResultSrcD;
            ex_d.branch      = BranchD;
            ex_d.alu_control = ALUControlD;
            ex_d.rd1         = RD1D;
            ex_d.rd2         = RD2D;
            ex_d.imm_ext     = ImmExtD;
            ex_d.pc          = PCD;
            ex_d.pc_plus4    = PCPlus4D;
            ex_d.rs1         = RS1D;
            ex_d.rs2         = RS2D;
            ex_d.rd          = RdD;
        end
    end

    // Bubble counter: one increment per cycle with a flush and/or load-use, holding at all-ones.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (insert_bubble_s && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Pipeline and counter state, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ValidE      = ex_q.valid;
    assign RegWriteE   = ex_q.reg_write;
    assign ALUSrcE     = ex_q.alu_src;
    assign MemWriteE   = ex_q.mem_write;
    assign ResultSrcE  = ex_q.result_src;
    assign BranchE     = ex_q.branch;
    assign ALUControlE = ex_q.alu_control;
    assign RD1E        = ex_q.rd1;
    assign RD2E        = ex_q.rd2;
    assign ImmExtE     = ex_q.imm_ext;
    assign PCE         = ex_q.pc;
    assign PCPlus4E    = ex_q.pc_plus4;
    assign RS1E        = ex_q.rs1;
    assign RS2E        = ex_q.rs2;
    assign RdE         = ex_q.rd;
    assign BubbleCnt   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg: reset, pass-through,
// load-use bubble, x0 exclusion, flush priority, mid-stream reset and counter saturation.
module tb_id_ex_stage_reg;

    logic        clk;
    logic        rst;
    logic        ValidD, RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [4:0]  RS1D, RS2D, RdD;
    logic        PCSrcE;

    logic        ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RS1E, RS2E, RdE;
    logic        StallF, StallD;
    logic [15:0] BubbleCnt;

    // Narrow-counter instance used for the saturation check.
    logic        ValidE4, RegWriteE4, ALUSrcE4, MemWriteE4, ResultSrcE4, BranchE4;
    logic [2:0]  ALUControlE4;
    logic [31:0] RD1E4, RD2E4, ImmExtE4, PCE4, PCPlus4E4;
    logic [4:0]  RS1E4, RS2E4, RdE4;
    logic        StallF4, StallD4;
    logic [3:0]  BubbleCnt4;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage_reg #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ValidD(ValidD), .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD),
        .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD), .BranchD(BranchD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RS1D(RS1D), .RS2D(RS2D), .RdD(RdD), .PCSrcE(PCSrcE),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RS1E(RS1E), .RS2E(RS2E), .RdE(RdE), .StallF(StallF), .StallD(StallD), .BubbleCnt(BubbleCnt)
    );

    id_ex_stage_reg #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .ValidD(ValidD), .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD),
        .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD), .BranchD(BranchD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RS1D(RS1D), .RS2D(RS2D), .RdD(RdD), .PCSrcE(PCSrcE),
        .ValidE(ValidE4), .RegWriteE(RegWriteE4), .ALUSrcE(ALUSrcE4), .MemWriteE(MemWriteE4),
        .ResultSrcE(ResultSrcE4), .BranchE(BranchE4), .ALUControlE(ALUControlE4),
        .RD1E(RD1E4), .RD2E(RD2E4), .ImmExtE(ImmExtE4), .PCE(PCE4), .PCPlus4E(PCPlus4E4),
        .RS1E(RS1E4), .RS2E(RS2E4), .RdE(RdE4), .StallF(StallF4), .StallD(StallD4), .BubbleCnt(BubbleCnt4)
    );

    // 10 ns core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic as, input logic mw,
                         input logic rs, input logic br, input logic [2:0] alu,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d);
        ValidD = v; RegWriteD = rw; ALUSrcD = as; MemWriteD = mw; ResultSrcD = rs; BranchD = br;
        ALUControlD = alu; RD1D = rd1; RD2D = rd2; ImmExtD = imm;
        PCD = pc; PCPlus4D = pc + 32'd4; RS1D = s1; RS2D = s2; RdD = d;
    endtask

    initial begin
        rst = 1'b1;
        PCSrcE = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check_eq("rst_valid", {31'd0, ValidE}, 32'd0);
        check_eq("rst_cnt", {16'd0, BubbleCnt}, 32'd0);
        check_eq("rst_stall", {30'd0, StallF, StallD}, 32'd0);
        rst = 1'b0;

        // Pass-through: add x3,x1,x2
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd5, 32'd7, 32'd0, 32'h100, 5'd1, 5'd2, 5'd3);
        check_eq("pt_stall_pre", {31'd0, StallF}, 32'd0);
        tick();
        check_eq("pt_valid", {31'd0, ValidE}, 32'd1);
        check_eq("pt_rd1", RD1E, 32'd5);
        check_eq("pt_rd2", RD2E, 32'd7);
        check_eq("pt_rd", {27'd0, RdE}, 32'd3);
        check_eq("pt_alu", {29'd0, ALUControlE}, 32'd0);
        check_eq("pt_pc", PCE, 32'h100);
        check_eq("pt_pc4", PCPlus4E, 32'h104);
        check_eq("pt_regwrite", {31'd0, RegWriteE}, 32'd1);
        check_eq("pt_stall", {30'd0, StallF, StallD}, 32'd0);

        // Store-like vector: MemWrite, Branch and non-zero ALU op must propagate
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 32'd9, 32'd10, 32'd12, 32'h200, 5'd4, 5'd3, 5'd0);
        tick();
        check_eq("sw_ctrl", {26'd0, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ValidE}, 32'b011011);
        check_eq("sw_alu", {29'd0, ALUControlE}, 32'd5);
        check_eq("sw_imm", ImmExtE, 32'd12);
        check_eq("sw_rs", {22'd0, RS1E, RS2E}, {22'd0, 5'd4, 5'd3});

        // Load-use: lw x5 then add x6,x5,x1
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'd8, 32'h300, 5'd1, 5'd0, 5'd5);
        tick();
        check_eq("lw_res", {31'd0, ResultSrcE}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd11, 32'd22, 32'd0, 32'h304, 5'd5, 5'd1, 5'd6);
        #1;
        check_eq("lu_stall", {30'd0, StallF, StallD}, 32'b11);
        tick();
        check_eq("lu_bubble_valid", {31'd0, ValidE}, 32'd0);
        check_eq("lu_bubble_ctrl", {29'd0, RegWriteE, MemWriteE, BranchE}, 32'd0);
        check_eq("lu_bubble_rd", {27'd0, RdE}, 32'd0);
        check_eq("lu_cnt", {16'd0, BubbleCnt}, 32'd1);
        check_eq("lu_stall_after", {30'd0, StallF, StallD}, 32'd0);
        tick();
        check_eq("lu_add_valid", {31'd0, ValidE}, 32'd1);
        check_eq("lu_add_rd", {27'd0, RdE}, 32'd6);
        check_eq("lu_add_rd1", RD1E, 32'd11);
        check_eq("lu_cnt_hold", {16'd0, BubbleCnt}, 32'd1);

        // x0 exclusion: lw x0 then add x7,x0,x0
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'd4, 32'h400, 5'd2, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd1, 32'd2, 32'd0, 32'h404, 5'd0, 5'd0, 5'd7);
        #1;
        check_eq("x0_stall", {30'd0, StallF, StallD}, 32'd0);
        tick();
        check_eq("x0_rd", {27'd0, RdE}, 32'd7);
        check_eq("x0_cnt", {16'd0, BubbleCnt}, 32'd1);

        // Invalid D: fields captured, ValidE low
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 32'h55, 32'd0, 32'd0, 32'h500, 5'd1, 5'd2, 5'd9);
        tick();
        check_eq("inv_valid", {31'd0, ValidE}, 32'd0);
        check_eq("inv_rd1", RD1E, 32'h55);
        check_eq("inv_rd", {27'd0, RdE}, 32'd9);

        // Flush overrides stall: lw x5, then add x5-dependent with PCSrcE
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'd8, 32'h600, 5'd1, 5'd0, 5'd5);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 32'd3, 32'd4, 32'd0, 32'h604, 5'd2, 5'd5, 5'd6);
        PCSrcE = 1'b1;
        #1;
        check_eq("fl_stall", {30'd0, StallF, StallD}, 32'd0);
        tick();
        PCSrcE = 1'b0;
        check_eq("fl_valid", {31'd0, ValidE}, 32'd0);
        check_eq("fl_ctrl", {26'd0, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE[0]}, 32'd0);
        check_eq("fl_alu", {29'd0, ALUControlE}, 32'd0);
        check_eq("fl_cnt", {16'd0, BubbleCnt}, 32'd2);

        // Same D instruction again: now passes through
        tick();
        check_eq("fl_after_rd", {27'd0, RdE}, 32'd6);
        check_eq("fl_after_valid", {31'd0, ValidE}, 32'd1);

        // Mid-stream asynchronous reset
        #3;
        rst = 1'b1;
        #1;
        check_eq("mrst_valid", {31'd0, ValidE}, 32'd0);
        check_eq("mrst_rd1", RD1E, 32'd0);
        check_eq("mrst_cnt", {16'd0, BubbleCnt}, 32'd0);
        check_eq("mrst_stall", {30'd0, StallF, StallD}, 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 32'd77, 32'd0, 32'd0, 32'h700, 5'd1, 5'd2, 5'd10);
        check_eq("mrst_held", {27'd0, RdE}, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("mrst_cap_rd", {27'd0, RdE}, 32'd10);
        check_eq("mrst_cap_rd1", RD1E, 32'd77);

        // Saturation: 20 consecutive flushes
        PCSrcE = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check_eq("sat_cnt4_14", {28'd0, BubbleCnt4}, 32'd14);
        for (int i = 0; i < 6; i++) tick();
        check_eq("sat_cnt4_20", {28'd0, BubbleCnt4}, 32'hF);
        check_eq("sat_cnt16_20", {16'd0, BubbleCnt}, 32'd20);
        tick();
        check_eq("sat_cnt4_21", {28'd0, BubbleCnt4}, 32'hF);
        check_eq("sat_cnt16_21", {16'd0, BubbleCnt}, 32'd21);
        PCSrcE = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
